fir_fsm: RTL and testbench

FIR_FSM -- requirements
Module: fir_fsm

---
 rtl/fir_fsm_pkg.sv | 25 ++
 rtl/fir_fsm.sv | 134 +++++++++++++
 tb/tb_fir_fsm.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_fsm_pkg.sv
// Shared types for the FIR job sequencer: state encoding and latched job descriptor.
package fir_package;

  localparam int unsigned FIR_ADDR_W = 32;
  localparam int unsigned FIR_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_H,
    WAIT_H,
    START_XY,
    COMPUTE,
    FLUSH,
    DONE
  } fir_fsm_state_t;

  // Fields are sized for the default fir_fsm widths; widen these if the module is built wider.
  typedef struct packed {
    logic [FIR_ADDR_W-1:0] x_addr;
    logic [FIR_ADDR_W-1:0] h_addr;
    logic [FIR_ADDR_W-1:0] y_addr;
    logic [FIR_LEN_W-1:0]  len;
  } fir_fsm_job_t;

endpackage

// File: rtl/fir_fsm.sv
// FIR job sequencer: loads taps, launches x/y streams, counts outputs, flushes and reports done.
// Optional job cycle counter enabled by defining FIR_FSM_PERF_CNT_EN.
module fir_fsm
  import fir_package::*;
#(
  parameter int unsigned NB_TAPS    = 50,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] x_addr_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [ADDR_WIDTH-1:0] y_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  h_start_o,
  output logic                  x_start_o,
  output logic                  y_start_o,
  output logic [ADDR_WIDTH-1:0] h_addr_o,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic [ADDR_WIDTH-1:0] y_addr_o,
  output logic [LEN_WIDTH-1:0]  h_len_o,
  output logic [LEN_WIDTH-1:0]  x_len_o,
  output logic [LEN_WIDTH-1:0]  y_len_o,
  input  logic                  taps_loaded_i,
  input  logic                  y_valid_i,
  input  logic                  y_ready_i,
  input  logic                  y_done_i,
  output logic                  dp_clear_o,
  output logic                  dp_enable_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           cycles_o
);

  fir_fsm_state_t       state_q, state_d;
  fir_fsm_job_t         job_q;
  logic [LEN_WIDTH-1:0] h_len_q, x_len_q, out_cnt_q;
  logic                 accept, handshake;

  assign accept    = (state_q == IDLE) && start_i && !clear_i;
  assign handshake = y_valid_i && y_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (start_i) state_d = (len_i == '0) ? DONE : LOAD_H;
        LOAD_H:   state_d = WAIT_H;
        WAIT_H:   if (taps_loaded_i) state_d = START_XY;
        START_XY: state_d = COMPUTE;
        COMPUTE:  if (out_cnt_q == job_q.len) state_d = FLUSH;
        FLUSH:    if (y_done_i) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Job descriptor is only captured for real jobs; a zero-length start leaves the previous one visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job_q   <= '0;
      h_len_q <= '0;
      x_len_q <= '0;
    end else if (accept && (len_i != '0)) begin
      job_q   <= '{x_addr: x_addr_i, h_addr: h_addr_i, y_addr: y_addr_i, len: len_i};
      h_len_q <= LEN_WIDTH'(NB_TAPS);
      x_len_q <= len_i + LEN_WIDTH'(NB_TAPS - 1);
    end
  end

  // Saturates at len so late handshakes in the exit cycle of COMPUTE are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   out_cnt_q <= '0;
    else if (clear_i || accept)  out_cnt_q <= '0;
    else if ((state_q == COMPUTE) && handshake && (out_cnt_q != job_q.len))
      out_cnt_q <= out_cnt_q + 1'b1;
  end

  always_comb begin
    h_start_o   = 1'b0;
    x_start_o   = 1'b0;
    y_start_o   = 1'b0;
    dp_clear_o  = 1'b0;
    dp_enable_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      LOAD_H: begin
        h_start_o  = 1'b1;
        dp_clear_o = 1'b1;
      end
      START_XY: begin
        x_start_o = 1'b1;
        y_start_o = 1'b1;
      end
      COMPUTE: dp_enable_o = 1'b1;
      DONE:    done_o      = 1'b1;
      default: ;
    endcase
  end

  assign h_addr_o = job_q.h_addr;
  assign x_addr_o = job_q.x_addr;
  assign y_addr_o = job_q.y_addr;
  assign h_len_o  = h_len_q;
  assign x_len_o  = x_len_q;
  assign y_len_o  = job_q.len;

`ifdef FIR_FSM_PERF_CNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  cycles_q <= '0;
    else if (clear_i || accept) cycles_q <= '0;
    else if (state_q != IDLE)   cycles_q <= cycles_q + 32'd1;
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_fir_fsm.sv
// Directed self-checking bench for fir_fsm (default parameters, NB_TAPS=50).
module tb_fir_fsm;

  logic        clk, rst, clear, start;
  logic [31:0] x_addr, h_addr, y_addr;
  logic [15:0] len;
  logic        taps_loaded, y_valid, y_ready, y_done;
  logic        h_start, x_start, y_start;
  logic [31:0] h_addr_q, x_addr_q, y_addr_q;
  logic [15:0] h_len, x_len, y_len;
  logic        dp_clear, dp_enable, busy, done;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;
  int h_pulses = 0, x_pulses = 0, y_pulses = 0, done_pulses = 0, busy_cycles = 0;

  fir_fsm #(.NB_TAPS(50), .LEN_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
    .x_addr_i(x_addr), .h_addr_i(h_addr), .y_addr_i(y_addr), .len_i(len),
    .h_start_o(h_start), .x_start_o(x_start), .y_start_o(y_start),
    .h_addr_o(h_addr_q), .x_addr_o(x_addr_q), .y_addr_o(y_addr_q),
    .h_len_o(h_len), .x_len_o(x_len), .y_len_o(y_len),
    .taps_loaded_i(taps_loaded), .y_valid_i(y_valid), .y_ready_i(y_ready), .y_done_i(y_done),
    .dp_clear_o(dp_clear), .dp_enable_o(dp_enable), .busy_o(busy), .done_o(done),
    .cycles_o(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (h_start) h_pulses++;
    if (x_start) x_pulses++;
    if (y_start) y_pulses++;
    if (done)    done_pulses++;
    if (busy)    busy_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({h_start, x_start, y_start, dp_clear, dp_enable, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {h_start, x_start, y_start, dp_clear, dp_enable, busy, done});
    end
    checks++;
    if ({h_addr_q, x_addr_q, y_addr_q, h_len, x_len, y_len, cycles} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {h_addr_q, x_addr_q, y_addr_q, h_len, x_len, y_len, cycles});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal();
    int h0 = h_pulses, x0 = x_pulses, y0 = y_pulses, d0 = done_pulses;
    logic [4:0] pat = 5'b11101;
    x_addr = 32'h0000_1000; h_addr = 32'h0000_2000; y_addr = 32'h0000_3000; len = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({h_start, dp_clear, busy, x_start} !== 4'b1110) begin
      errors++;
      $display("FAIL load_h got %b exp 1110", {h_start, dp_clear, busy, x_start});
    end
    checks++;
    if (x_len !== 16'd53 || h_len !== 16'd50 || y_len !== 16'd4) begin
      errors++;
      $display("FAIL lengths got h=%0d x=%0d y=%0d exp h=50 x=53 y=4", h_len, x_len, y_len);
    end
    checks++;
    if (h_addr_q !== 32'h2000 || x_addr_q !== 32'h1000 || y_addr_q !== 32'h3000) begin
      errors++;
      $display("FAIL addrs got h=%h x=%h y=%h exp 2000 1000 3000", h_addr_q, x_addr_q, y_addr_q);
    end
    tick();
    tick();
    taps_loaded = 1'b1;
    tick();
    taps_loaded = 1'b0;
    checks++;
    if ({x_start, y_start, h_start} !== 3'b110) begin
      errors++;
      $display("FAIL start_xy got %b exp 110", {x_start, y_start, h_start});
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      y_valid = pat[i];
      y_ready = 1'b1;
      tick();
      checks++;
      if (dp_enable !== 1'b1) begin
        errors++;
        $display("FAIL compute_en_%0d got %b exp 1", i, dp_enable);
      end
    end
    y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    checks++;
    if ({dp_enable, busy, done} !== 3'b010) begin
      errors++;
      $display("FAIL flush got %b exp 010", {dp_enable, busy, done});
    end
    tick();
    y_done = 1'b1;
    tick();
    y_done = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL normal_done got %b exp 1", done);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL normal_idle got %b exp 00", {busy, done});
    end
    checks++;
    if ((h_pulses - h0) != 1 || (x_pulses - x0) != 1 || (y_pulses - y0) != 1 || (done_pulses - d0) != 1) begin
      errors++;
      $display("FAIL normal_pulses got h=%0d x=%0d y=%0d d=%0d exp 1 each",
               h_pulses - h0, x_pulses - x0, y_pulses - y0, done_pulses - d0);
    end
  endtask

  task automatic test_zero_len();
    int h0 = h_pulses, x0 = x_pulses, b0 = busy_cycles, d0 = done_pulses;
    len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b11) begin
      errors++;
      $display("FAIL zero_done got %b exp 11", {done, busy});
    end
    tick();
    tick();
    checks++;
    if ((h_pulses - h0) != 0 || (x_pulses - x0) != 0 || (busy_cycles - b0) != 1 || (done_pulses - d0) != 1) begin
      errors++;
      $display("FAIL zero_counts got h=%0d x=%0d busy=%0d done=%0d exp 0 0 1 1",
               h_pulses - h0, x_pulses - x0, busy_cycles - b0, done_pulses - d0);
    end
  endtask

  task automatic test_clear();
    int d0 = done_pulses;
    len = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    taps_loaded = 1'b1;
    tick();
    taps_loaded = 1'b0;
    tick();
    y_valid = 1'b1; y_ready = 1'b1;
    tick();
    tick();
    y_valid = 1'b0;
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, dp_enable, done} !== 3'b000) begin
      errors++;
      $display("FAIL clear_idle got %b exp 000", {busy, dp_enable, done});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio got %b exp 0", busy);
    end
    len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    taps_loaded = 1'b1;
    tick();
    tick();
    taps_loaded = 1'b0;
    tick();
    y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    tick();
    y_done = 1'b1;
    tick();
    y_done = 1'b0;
    checks++;
    if (done !== 1'b1 || y_len !== 16'd1) begin
      errors++;
      $display("FAIL after_clear_done got done=%b ylen=%0d exp 1 1", done, y_len);
    end
    tick();
    checks++;
    if ((done_pulses - d0) != 1) begin
      errors++;
      $display("FAIL clear_done_count got %0d exp 1", done_pulses - d0);
    end
  endtask

  task automatic test_start_ignored();
    int d0 = done_pulses;
    x_addr = 32'hA000_0001; h_addr = 32'hA000_0002; y_addr = 32'hA000_0003; len = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    x_addr = 32'hB000_0001; h_addr = 32'hB000_0002; y_addr = 32'hB000_0003; len = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (x_addr_q !== 32'hA000_0001 || h_addr_q !== 32'hA000_0002 || y_addr_q !== 32'hA000_0003 || y_len !== 16'd2) begin
      errors++;
      $display("FAIL ignore_latch got x=%h h=%h y=%h len=%0d exp A0000001 A0000002 A0000003 2",
               x_addr_q, h_addr_q, y_addr_q, y_len);
    end
    checks++;
    if ({busy, h_start, x_start} !== 3'b100) begin
      errors++;
      $display("FAIL ignore_state got %b exp 100", {busy, h_start, x_start});
    end
    taps_loaded = 1'b1;
    tick();
    taps_loaded = 1'b0;
    tick();
    y_valid = 1'b1; y_ready = 1'b1;
    tick();
    tick();
    y_valid = 1'b0;
    tick();
    y_done = 1'b1;
    tick();
    y_done = 1'b0;
    tick();
    tick();
    checks++;
    if ((done_pulses - d0) != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done got done=%0d busy=%b exp 1 0", done_pulses - d0, busy);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    x_addr = 32'h1234_5678; len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    taps_loaded = 1'b1;
    tick();
    tick();
    taps_loaded = 1'b0;
    tick();
    y_valid = 1'b1; y_ready = 1'b1;
    tick();
    y_valid = 1'b0;
    tick();
    checks++;
    if ({busy, dp_enable} !== 2'b10 || x_addr_q !== 32'h1234_5678) begin
      errors++;
      $display("FAIL pre_reset_flush got %b addr=%h exp 10 12345678", {busy, dp_enable}, x_addr_q);
    end
    d0 = done_pulses;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, h_start, x_start, y_start, dp_clear, dp_enable} !== 7'b0 ||
        {h_addr_q, x_addr_q, y_addr_q, h_len, x_len, y_len, cycles} !== '0) begin
      errors++;
      $display("FAIL async_reset got ctrl=%b addr=%h exp 0", {busy, done}, x_addr_q);
    end
    y_done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    y_done = 1'b0;
    checks++;
    if ((done_pulses - d0) != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done=%0d busy=%b exp 0 0", done_pulses - d0, busy);
    end
  endtask

  task automatic test_perf();
    int b0 = busy_cycles, d0 = done_pulses;
    taps_loaded = 1'b1; y_valid = 1'b1; y_ready = 1'b1; y_done = 1'b1;
    len = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    taps_loaded = 1'b0; y_valid = 1'b0; y_done = 1'b0;
    checks++;
    if ((busy_cycles - b0) != 7 || (done_pulses - d0) != 1) begin
      errors++;
      $display("FAIL perf_job got busy=%0d done=%0d exp 7 1", busy_cycles - b0, done_pulses - d0);
    end
`ifdef FIR_FSM_PERF_CNT_EN
    checks++;
    if (cycles !== 32'(busy_cycles - b0)) begin
      errors++;
      $display("FAIL perf_cycles got %0d exp %0d", cycles, busy_cycles - b0);
    end
`else
    checks++;
    if (cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_tied got %0d exp 0", cycles);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0;
    x_addr = '0; h_addr = '0; y_addr = '0; len = '0;
    taps_loaded = 1'b0; y_valid = 1'b0; y_ready = 1'b0; y_done = 1'b0;
    test_reset();
    test_normal();
    test_zero_len();
    test_clear();
    test_start_ignored();
    test_async_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
